// File: rtl/writeback_stage.sv
// writeback_stage: WB pipeline register, register-file write port and a
// per-register scoreboard of in-flight writes used by decode for RAW stalls.
// Optional macro FORWARD_EN enables a bypass from the WB register to decode
// so that a source whose only pending write is sitting in WB does not stall.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_issue_valid,
  input  logic              i_issue_we,
  input  logic [ADDR_W-1:0] i_issue_dest,
  output logic              o_issue_full,
  input  logic              i_res_valid,
  input  logic              i_res_we,
  input  logic [ADDR_W-1:0] i_res_dest,
  input  logic              i_res_memtoreg,
  input  logic [DATA_W-1:0] i_res_alu,
  input  logic [DATA_W-1:0] i_res_mem,
  input  logic [ADDR_W-1:0] i_src_add1,
  input  logic [ADDR_W-1:0] i_src_add2,
  output logic              o_stall,
  output logic              o_write_en,
  output logic [ADDR_W-1:0] o_write_add,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_fwd_hit1,
  output logic              o_fwd_hit2,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic              o_sb_error
);

  localparam int NREG = 2 ** ADDR_W;

  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_sb_error;
  logic [1:0]        r_cnt [NREG];

  logic              w_issue_full;
  logic              w_inc;
  logic [NREG-1:0]   w_inc_vec;
  logic [NREG-1:0]   w_dec_vec;
  logic              w_dec_zero;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_haz1;
  logic              w_haz2;

  // An issue is refused while its destination counter is saturated.
  assign w_issue_full = i_issue_valid & i_issue_we & (r_cnt[i_issue_dest] == 2'd3);
  assign w_inc        = i_issue_valid & i_issue_we & ~w_issue_full;
  assign w_dec_zero   = r_wb_valid & (r_cnt[r_wb_dest] == 2'd0);

  // One-hot increment/decrement selects per scoreboard entry.
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      w_inc_vec[i] = w_inc      & (i_issue_dest == ADDR_W'(i));
      w_dec_vec[i] = r_wb_valid & (r_wb_dest    == ADDR_W'(i));
    end
  end

  // WB pipeline register; results that do not write create no entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wb_valid <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= i_res_valid & i_res_we;
      r_wb_dest  <= i_res_dest;
      r_wb_data  <= i_res_memtoreg ? i_res_mem : i_res_alu;
    end
  end

  // Pending-write counters; an inc and dec on the same entry cancel.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i])
          r_cnt[i] <= r_cnt[i] + 2'd1;
        else if (w_dec_vec[i] && !w_inc_vec[i] && (r_cnt[i] != 2'd0))
          r_cnt[i] <= r_cnt[i] - 2'd1;
      end
    end
  end

  // Sticky flag for a retire that the scoreboard never saw issued.
  always_ff @(posedge i_clk) begin
    if (i_reset)         r_sb_error <= 1'b0;
    else if (w_dec_zero) r_sb_error <= 1'b1;
  end

`ifdef FORWARD_EN
  // Bypass only when the write in WB is the sole outstanding write.
  assign w_fwd1 = r_wb_valid & (r_wb_dest == i_src_add1) & (r_cnt[i_src_add1] == 2'd1);
  assign w_fwd2 = r_wb_valid & (r_wb_dest == i_src_add2) & (r_cnt[i_src_add2] == 2'd1);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  assign w_haz1 = (r_cnt[i_src_add1] != 2'd0) & ~w_fwd1;
  assign w_haz2 = (r_cnt[i_src_add2] != 2'd0) & ~w_fwd2;

  assign o_issue_full = w_issue_full;
  assign o_stall      = w_haz1 | w_haz2 | w_issue_full;
  assign o_write_en   = r_wb_valid;
  assign o_write_add  = r_wb_dest;
  assign o_write_data = r_wb_data;
  assign o_fwd_hit1   = w_fwd1;
  assign o_fwd_hit2   = w_fwd2;
  assign o_fwd_data   = r_wb_data;
  assign o_sb_error   = r_sb_error;

endmodule
